// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: queues add/sub commands, issues them one at a time to
// MINHA_FPU, holds operands for FPU_LATENCY cycles, then captures the result
// and status for a valid/ready response. Keeps an OR-accumulated sticky status.
// Optional feature macro: FPU_ISSUE_SEQ_TAG_EN adds an 8-bit sequence tag
// that follows each command and is returned on rsp_tag.
module fpu_issue_ctrl #(
  parameter int unsigned FPU_LATENCY = 10,
  parameter int unsigned CMD_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_op,
  output logic [31:0] fpu_op_a,
  output logic [31:0] fpu_op_b,
  output logic        fpu_op_select,
  input  logic [31:0] fpu_data,
  input  logic [3:0]  fpu_status,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_status,
  output logic [3:0]  sticky_status,
  input  logic        clear_sticky,
  output logic        busy
`ifdef FPU_ISSUE_SEQ_TAG_EN
  ,
  output logic [7:0]  rsp_tag
`endif
);

  localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned CNT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;

  typedef struct packed {
`ifdef FPU_ISSUE_SEQ_TAG_EN
    logic [7:0]  tag;
`endif
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  cmd_entry_t fifo_mem [CMD_DEPTH];
  cmd_entry_t wr_entry_c;
  cmd_entry_t head_c;

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_nxt_c;

  state_t           state;
  state_t           state_nxt_c;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt_c;

  logic push_c;
  logic pop_c;
  logic capture_c;
  logic rsp_done_c;
  logic empty_c;

`ifdef FPU_ISSUE_SEQ_TAG_EN
  logic [7:0] seq_tag;
  logic [7:0] issue_tag;
`endif

  assign empty_c   = (occ == '0);
  assign cmd_ready = (occ != OCC_W'(CMD_DEPTH)) && !reset;
  assign push_c    = cmd_valid && cmd_ready;
  assign head_c    = fifo_mem[rptr];

  // Pack the incoming command into a FIFO entry
  always_comb begin
    wr_entry_c    = '0;
    wr_entry_c.op = cmd_op;
    wr_entry_c.a  = cmd_a;
    wr_entry_c.b  = cmd_b;
`ifdef FPU_ISSUE_SEQ_TAG_EN
    wr_entry_c.tag = seq_tag;
`endif
  end

  // Occupancy after this edge's push/pop
  always_comb begin
    occ_nxt_c = occ;
    case ({push_c, pop_c})
      2'b10:   occ_nxt_c = occ + OCC_W'(1);
      2'b01:   occ_nxt_c = occ - OCC_W'(1);
      default: occ_nxt_c = occ;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_mem[wptr] <= wr_entry_c;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push_c) wptr <= wptr + PTR_W'(1);
      if (pop_c)  rptr <= rptr + PTR_W'(1);
      occ <= occ_nxt_c;
    end
  end

  // FSM state and hold counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt_c;
      cnt   <= cnt_nxt_c;
    end
  end

  // FSM next state: issue from FIFO, hold operands, then present the response
  always_comb begin
    state_nxt_c = state;
    cnt_nxt_c   = cnt;
    pop_c       = 1'b0;
    capture_c   = 1'b0;
    rsp_done_c  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_c) begin
          pop_c       = 1'b1;
          cnt_nxt_c   = CNT_W'(FPU_LATENCY - 1);
          state_nxt_c = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nxt_c = cnt - CNT_W'(1);
        end else begin
          capture_c   = 1'b1;
          state_nxt_c = DONE;
        end
      end
      DONE: begin
        if (rsp_valid && rsp_ready) begin
          rsp_done_c  = 1'b1;
          state_nxt_c = IDLE;
        end
      end
      default: state_nxt_c = IDLE;
    endcase
  end

  // Operand issue, result capture, sticky flags and busy
  always_ff @(posedge clk) begin
    if (reset) begin
      fpu_op_a      <= '0;
      fpu_op_b      <= '0;
      fpu_op_select <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_status    <= '0;
      sticky_status <= '0;
      busy          <= 1'b0;
    end else begin
      if (pop_c) begin
        fpu_op_a      <= head_c.a;
        fpu_op_b      <= head_c.b;
        fpu_op_select <= head_c.op;
      end
      if (capture_c) begin
        rsp_data   <= fpu_data;
        rsp_status <= fpu_status;
        rsp_valid  <= 1'b1;
      end else if (rsp_done_c) begin
        rsp_valid <= 1'b0;
      end
      // A capture on a clearing edge keeps the new status
      if (capture_c) begin
        sticky_status <= (clear_sticky ? 4'b0000 : sticky_status) | fpu_status;
      end else if (clear_sticky) begin
        sticky_status <= '0;
      end
      busy <= (state_nxt_c != IDLE) || (occ_nxt_c != '0);
    end
  end

`ifdef FPU_ISSUE_SEQ_TAG_EN
  // Sequence tag: assigned at acceptance, follows the command to the response
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_tag   <= '0;
      issue_tag <= '0;
      rsp_tag   <= '0;
    end else begin
      if (push_c)    seq_tag   <= seq_tag + 8'd1;
      if (pop_c)     issue_tag <= head_c.tag;
      if (capture_c) rsp_tag   <= issue_tag;
    end
  end
`endif

endmodule
